pc_next_unit: RTL and testbench
===============================

// Module: pc_next_unit
// PURPOSE
//  Program-counter stage downstream of the branch selector. Owns the PC
//  register and the instruction-fetch handshake to instruction memory.
//  Each cycle it picks the next PC: sequential, taken branch, JAL or JALR.
//  The branch decision is the selector's en_branch, qualified by the decoder's branch.
// PARAMETERS
//  XLEN      32            datapath/PC width in bits
//  RESET_PC  32'h0000_0000 PC value loaded on reset
// PORTS
//  clk        in   1     system clock, all state updates on rising edge
//  rst        in   1     synchronous, active-high reset
//  branch     in   1     decoder: current instruction is a conditional branch
//  en_branch  in   1     branch selector: condition satisfied
//  jal        in   1     decoder: current instruction is JAL
//  jalr       in   1     decoder: current instruction is JALR
//  imm        in   XLEN  sign-extended immediate (B/J/I type)
//  rs1_val    in   XLEN  register-file rs1 read data (JALR base)
//  stall      in   1     hold current instruction in EXEC (e.g. multi-cycle mem)
//  imem_ready in   1     instruction memory has returned instr at pc
//  imem_req   out  1     fetch request for address pc
//  pc         out  XLEN  current PC (fetch address)
//  pc_plus4   out  XLEN  pc+4, combinational, for JAL/JALR link writeback
//  pc_valid   out  1     instruction at pc is in EXEC; commit allowed
//  misalign   out  1     sticky misaligned-target flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, imem_req=0, pc_valid=0, misalign=0.
//   rst wins over every other input in any state, including mid-fetch/stall.
//  FSM (3 states + HALT when macro on):
//   IDLE : imem_req=0, pc_valid=0; unconditionally -> FETCH next cycle.
//   FETCH: imem_req=1, pc_valid=0; imem_ready=1 -> EXEC, else stay.
//   EXEC : imem_req=0, pc_valid=1. stall=1 -> stay, pc held.
//          stall=0 -> pc<=next_pc, -> FETCH. One instruction per EXEC.
//  next_pc priority (evaluated only in EXEC):
//   1 jalr             : (rs1_val + imm) & ~1
//   2 jal              : pc + imm
//   3 branch&en_branch : pc + imm
//   4 otherwise        : pc + 4
//   en_branch ignored when branch=0. jal and jalr both set: jalr wins.
//  Arithmetic: XLEN-bit unsigned add, carry discarded (wrap mod 2^XLEN);
//   pc=FFFF_FFFC sequential -> 0000_0000. imm taken as two's complement.
//  Minimum latency: IDLE->FETCH 1 cycle; FETCH->EXEC on the cycle
//   imem_ready is seen; steady state 2 cycles/instr with imem_ready=1.
//  imem_ready outside FETCH is ignored. pc changes only on EXEC exit or rst.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined:
//   In EXEC with stall=0, if next_pc[1:0]!=0: pc not updated, misalign<=1,
//   -> HALT (imem_req=0, pc_valid=0) until rst. Target check uses the
//   final next_pc (after JALR bit-0 clear).
//  Not defined: no check, no HALT state, misalign tied 0; next_pc loaded
//   as computed (bit 1 may be set).
// TESTING
//  1 rst 1 cycle, imem_ready=1 -> pc=0, IDLE,FETCH,EXEC; pc=4 on 4th edge.
//  2 pc=0x100, branch=1,en_branch=1,imm=-8 -> pc=0x0F8; en_branch=0 -> 0x104.
//  3 branch=0,en_branch=1 at pc=0x20 -> pc=0x24 (en_branch masked).
//  4 jalr rs1=0x1001,imm=4 -> pc=0x1004; jal+jalr both set -> jalr target.
//  5 EXEC stall=1 for 3 cycles -> pc, pc_valid=1 held; imem_ready low 5
//    cycles in FETCH -> imem_req held, pc unchanged; rst mid-stall -> pc=0.
//  6 pc=FFFF_FFFC seq -> 0; macro on, jal imm=2 -> misalign=1, HALT, pc held.

Source files
------------

// File: rtl/pc_next_unit.sv
// ---------------------------------------------------------------------------
// pc_next_unit
//
// Program-counter stage that sits after the branch selector. It owns the PC
// register and the fetch handshake to instruction memory. It runs as a
// small sequencer: IDLE -> FETCH (wait for imem_ready) -> EXEC (hold while
// stalled). On leaving EXEC it loads the next PC, chosen in priority order:
// JALR, JAL, taken branch, sequential.
//
// Optional feature, selected with the macro PC_MISALIGN_TRAP_EN:
//   The target is checked for 4-byte alignment when EXEC retires. A
//   misaligned target leaves pc unchanged, sets the sticky misalign flag and
//   parks the unit in HALT until reset. Without the macro there is no check
//   and no HALT state, and misalign is tied low.
//
// Handshake: imem_req is high in every FETCH cycle. The fetch completes on
// the first rising edge where imem_req and imem_ready are both high.
// imem_ready is ignored in all other states. pc_valid is high for every
// EXEC cycle. The instruction retires on the edge where pc_valid=1 and
// stall=0.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   branch        decoder: conditional branch
//   en_branch     branch selector: condition true (used only with branch)
//   jal, jalr     decoder: jump kinds (jalr has priority)
//   imm           sign-extended immediate
//   rs1_val       JALR base register value
//   stall         hold the current instruction in EXEC
//   imem_ready    instruction memory returned the word at pc
//   imem_req      fetch request for pc
//   pc            current PC / fetch address
//   pc_plus4      pc + 4 (link value)
//   pc_valid      instruction at pc is in EXEC
//   misalign      sticky misaligned-target flag
//   dbg_state     current sequencer state, for observation only
// ---------------------------------------------------------------------------
module pc_next_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch,
    input  logic            en_branch,
    input  logic            jal,
    input  logic            jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            stall,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_valid,
    output logic            misalign,
    output logic [1:0]      dbg_state
);

`ifdef PC_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] next_pc;

    // All adds are XLEN wide. The carry falls off, so targets wrap mod 2^XLEN.
    assign pc_plus4 = pc_q + XLEN'(4);
    assign jalr_sum = rs1_val + imm;

    always_comb begin
        next_pc = pc_plus4;
        if (jalr) begin
            next_pc = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (jal) begin
            next_pc = pc_q + imm;
        end else if (branch && en_branch) begin
            next_pc = pc_q + imm;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        imem_req = 1'b0;
        pc_valid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_valid = 1'b1;
                if (!stall) begin
`ifdef PC_MISALIGN_TRAP_EN
                    // Check the final target. For JALR this is after bit 0
                    // has been cleared.
                    if (next_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end
`else
                    pc_d    = next_pc;
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef PC_MISALIGN_TRAP_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`endif

    assign pc        = pc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch, en_branch, jal, jalr;
  logic [31:0] imm, rs1_val;
  logic        stall, imem_ready;
  logic        imem_req, pc_valid, misalign;
  logic [31:0] pc, pc_plus4;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  pc_next_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .branch(branch), .en_branch(en_branch),
    .jal(jal), .jalr(jalr), .imm(imm), .rs1_val(rs1_val), .stall(stall),
    .imem_ready(imem_ready), .imem_req(imem_req), .pc(pc),
    .pc_plus4(pc_plus4), .pc_valid(pc_valid), .misalign(misalign),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural model: phase names, pc, sticky flag
  typedef enum int {P_NONE, P_IDLE, P_FETCH, P_EXEC, P_HALT} phase_t;
  phase_t      m_phase = P_NONE;
  logic [31:0] m_pc = '0;
  logic        m_mis = 1'b0;

  function automatic logic [31:0] target(input logic [31:0] cur);
    logic [31:0] t;
    if (jalr)                  t = (rs1_val + imm) & 32'hFFFF_FFFE;
    else if (jal)              t = cur + imm;
    else if (branch && en_branch) t = cur + imm;
    else                       t = cur + 32'd4;
    return t;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = P_IDLE;
      m_pc    = 32'h0;
      m_mis   = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE:  m_phase = P_FETCH;
        P_FETCH: if (imem_ready) m_phase = P_EXEC;
        P_EXEC: begin
          if (!stall) begin
            logic [31:0] t;
            t = target(m_pc);
`ifdef PC_MISALIGN_TRAP_EN
            if (t % 4 != 0) begin
              m_mis   = 1'b1;
              m_phase = P_HALT;
            end else begin
              m_pc    = t;
              m_phase = P_FETCH;
            end
`else
            m_pc    = t;
            m_phase = P_FETCH;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // compare process: every cycle once the model is known
  always @(negedge clk) begin
    if (m_phase != P_NONE) begin
      checks++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 ||
          imem_req !== (m_phase == P_FETCH) ||
          pc_valid !== (m_phase == P_EXEC) || misalign !== m_mis) begin
        errors++;
        $display("FAIL model_cmp t=%0t act pc=%h p4=%h req=%b val=%b mis=%b exp pc=%h req=%b val=%b mis=%b",
                 $time, pc, pc_plus4, imem_req, pc_valid, misalign, m_pc,
                 m_phase == P_FETCH, m_phase == P_EXEC, m_mis);
      end
    end
  end

  // literal checks that pin the model
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic clr_instr();
    branch = 0; en_branch = 0; jal = 0; jalr = 0; imm = '0; rs1_val = '0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (pc_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (pc_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout act=%b exp=1", name, pc_valid);
    end
  endtask

  // driver: run one instruction through EXEC with nstall held cycles
  task automatic run_instr(input string name, input logic b, input logic e,
                           input logic j, input logic jr, input logic [31:0] im,
                           input logic [31:0] r1, input int nstall);
    imem_ready = 1;
    wait_valid(name);
    branch = b; en_branch = e; jal = j; jalr = jr; imm = im; rs1_val = r1;
    stall = (nstall > 0);
    for (int i = 0; i < nstall; i++) @(negedge clk);
    stall = 0;
    @(negedge clk);
    clr_instr();
  endtask

  initial begin
    rst = 1; stall = 0; imem_ready = 1; clr_instr();
    @(negedge clk);
    rst = 0;
    // test 1: reset state and first instruction timing
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, pc_valid}, 32'h0);
    chk("rst_mis", {31'b0, misalign}, 32'h0);
    @(negedge clk);
    chk("fetch_req", {31'b0, imem_req}, 32'h1);
    @(negedge clk);
    chk("exec_valid", {31'b0, pc_valid}, 32'h1);
    chk("exec_pc", pc, 32'h0);
    @(negedge clk);
    chk("first_seq_pc", pc, 32'h4);

    // test 2: taken / not-taken branch
    run_instr("jal_to_100", 0, 0, 1, 0, 32'h0000_00FC, 32'h0, 0);
    chk("jal_pc", pc, 32'h100);
    run_instr("br_taken", 1, 1, 0, 0, 32'hFFFF_FFF8, 32'h0, 0);
    chk("br_taken_pc", pc, 32'h0F8);
    run_instr("jalr_100", 0, 0, 0, 1, 32'h0, 32'h100, 0);
    run_instr("br_nt", 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 0);
    chk("br_not_taken_pc", pc, 32'h104);

    // test 3: en_branch masked without branch
    run_instr("jalr_20", 0, 0, 0, 1, 32'h0, 32'h20, 0);
    run_instr("en_masked", 0, 1, 0, 0, 32'h0000_0040, 32'h0, 0);
    chk("en_masked_pc", pc, 32'h24);

    // test 4: jalr bit-0 clear, jalr beats jal
    run_instr("jalr_1004", 0, 0, 0, 1, 32'h4, 32'h1001, 0);
    chk("jalr_pc", pc, 32'h1004);
    run_instr("jal_jalr", 0, 0, 1, 1, 32'h10, 32'h200, 0);
    chk("jalr_prio_pc", pc, 32'h210);

    // test 5: stall hold, fetch wait, reset mid-stall
    run_instr("stall3", 0, 0, 0, 0, 32'h0, 32'h0, 3);
    chk("stall_pc", pc, 32'h214);
    imem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("fetch_wait_req", {31'b0, imem_req}, 32'h1);
      chk("fetch_wait_pc", pc, 32'h214);
    end
    imem_ready = 1;
    wait_valid("mid_stall");
    stall = 1;
    @(negedge clk);
    chk("stall_valid", {31'b0, pc_valid}, 32'h1);
    rst = 1;
    @(negedge clk);
    rst = 0; stall = 0;
    chk("rst_mid_stall_pc", pc, 32'h0);
    chk("rst_mid_stall_valid", {31'b0, pc_valid}, 32'h0);

    // test 6: wrap, and misaligned target
    run_instr("jalr_top", 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC, 0);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    run_instr("wrap", 0, 0, 0, 0, 32'h0, 32'h0, 0);
    chk("wrap_pc", pc, 32'h0);
    run_instr("jal_mis", 0, 0, 1, 0, 32'h2, 32'h0, 0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_flag", {31'b0, misalign}, 32'h1);
    chk("mis_pc_held", pc, 32'h0);
    @(negedge clk);
    chk("halt_req", {30'b0, imem_req, pc_valid}, 32'h0);
`else
    chk("mis_off_pc", pc, 32'h2);
    chk("mis_off_flag", {31'b0, misalign}, 32'h0);
`endif
    rst = 1;
    @(negedge clk);
    rst = 0;

    // random phase, checked by the compare process
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(63) == 0);
      imem_ready = $urandom_range(1);
      stall      = ($urandom_range(3) == 0);
      branch     = $urandom_range(1);
      en_branch  = $urandom_range(1);
      jal        = ($urandom_range(3) == 0);
      jalr       = ($urandom_range(3) == 0);
      imm        = ($urandom_range(1) == 1) ? {$urandom} : {{20{1'b0}}, 12'($urandom_range(4095))} & 32'hFFFF_FFFC;
      rs1_val    = $urandom;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
